// File: rtl/img_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : img_pkg                                                     |
// | Brief  : Shared pixel type, image width and row-bank state encoding. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package img_pkg;

    typedef byte pixel_t;

    localparam int IMG_W = 640;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/row_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : row_bank                                                    |
// | Brief  : One D-pixel row store with EMPTY/FILLING/FULL state and,    |
// |          under ROW_BUFFER_LAST_EN, a written-length register.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module row_bank
    import img_pkg::*;
#(
    parameter int D     = IMG_W,
    parameter int IDX_W = $clog2(D)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  pixel_t           wr_data,
    input  logic             wr_close,
    input  logic             rd_release,
    output logic             is_full,
    output pixel_t           rd_data [D]
);

    localparam logic [1:0] c_st_empty   = EMPTY;
    localparam logic [1:0] c_st_filling = FILLING;
    localparam logic [1:0] c_st_full    = FULL;

    logic [1:0] r_state;
    pixel_t     r_mem [D];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            case (r_state)
                c_st_empty:   if (wr_en) r_state <= wr_close ? c_st_full : c_st_filling;
                c_st_filling: if (wr_en && wr_close) r_state <= c_st_full;
                c_st_full:    if (rd_release) r_state <= c_st_empty;
                default:      r_state <= c_st_empty;
            endcase
        end
    end

    // Storage is not reset: the row is only visible once it has been fully written.
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_idx] <= wr_data;
    end

    assign is_full = (r_state == c_st_full);

`ifdef ROW_BUFFER_LAST_EN
    logic [IDX_W:0] r_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len <= '0;
        end else if (wr_en && wr_close) begin
            r_len <= {1'b0, wr_idx} + 1'b1;
        end
    end
`endif

    for (genvar i = 0; i < D; i++) begin : g_rd
`ifdef ROW_BUFFER_LAST_EN
        assign rd_data[i] = (r_len > (IDX_W + 1)'(i)) ? r_mem[i] : '0;
`else
        assign rd_data[i] = r_mem[i];
`endif
    end

endmodule
`default_nettype wire

// File: rtl/row_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : row_buffer                                                  |
// | Brief  : Ping-pong serial-to-row collector feeding conv_1d.          |
// |          Optional early-close support via macro ROW_BUFFER_LAST_EN.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module row_buffer
    import img_pkg::*;
#(
    parameter int D         = IMG_W,
    parameter int IDX_W     = $clog2(D),
    parameter int ROW_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  pixel_t               s_data,
`ifdef ROW_BUFFER_LAST_EN
    input  logic                 s_last,
    output logic                 err_len,
`endif
    output logic                 row_valid,
    input  logic                 row_ready,
    output pixel_t               row_data [D],
    output logic [ROW_CNT_W-1:0] row_idx
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(D - 1);

    logic                 r_wr_bank;
    logic                 r_rd_bank;
    logic [IDX_W-1:0]     r_wr_idx;
    logic [ROW_CNT_W-1:0] r_row_idx;

    logic   w_full0, w_full1;
    pixel_t w_data0 [D];
    pixel_t w_data1 [D];
    logic   w_accept, w_at_end, w_close, w_hs;

    assign w_accept = s_valid & s_ready;
    assign w_at_end = (r_wr_idx == c_last_idx);
`ifdef ROW_BUFFER_LAST_EN
    assign w_close  = w_accept & (w_at_end | s_last);
`else
    assign w_close  = w_accept & w_at_end;
`endif
    assign w_hs     = row_valid & row_ready;

    // Ready depends only on registered bank state and reset, never on s_valid.
    assign s_ready   = ~rst & ~(r_wr_bank ? w_full1 : w_full0);
    assign row_valid = r_rd_bank ? w_full1 : w_full0;
    assign row_idx   = r_row_idx;

    row_bank #(
        .D     (D),
        .IDX_W (IDX_W)
    ) u_bank0 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (w_accept & ~r_wr_bank),
        .wr_idx     (r_wr_idx),
        .wr_data    (s_data),
        .wr_close   (w_close & ~r_wr_bank),
        .rd_release (w_hs & ~r_rd_bank),
        .is_full    (w_full0),
        .rd_data    (w_data0)
    );

    row_bank #(
        .D     (D),
        .IDX_W (IDX_W)
    ) u_bank1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (w_accept & r_wr_bank),
        .wr_idx     (r_wr_idx),
        .wr_data    (s_data),
        .wr_close   (w_close & r_wr_bank),
        .rd_release (w_hs & r_rd_bank),
        .is_full    (w_full1),
        .rd_data    (w_data1)
    );

    always_comb begin
        for (int i = 0; i < D; i++) begin
            row_data[i] = '0;
            if (row_valid) row_data[i] = r_rd_bank ? w_data1[i] : w_data0[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= '0;
            r_row_idx <= '0;
        end else begin
            if (w_accept) begin
                r_wr_idx <= w_close ? '0 : r_wr_idx + 1'b1;
                if (w_close) r_wr_bank <= ~r_wr_bank;
            end
            if (w_hs) begin
                r_rd_bank <= ~r_rd_bank;
                r_row_idx <= r_row_idx + 1'b1;
            end
        end
    end

`ifdef ROW_BUFFER_LAST_EN
    logic r_err_len;

    // Flags both a short row (early last) and a missing last on the final pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_len <= 1'b0;
        end else begin
            r_err_len <= w_accept & (s_last ^ w_at_end);
        end
    end

    assign err_len = r_err_len;
`endif

endmodule
`default_nettype wire
